fetch_unit: RTL
===============

# fetch_unit

Instruction fetch front end for the RISC-V core. It sits upstream of the main/ALU decoder. It holds the fetch PC and issues word requests to instruction memory over a request/grant/response handshake. Returned words are buffered in a small FIFO and presented to decode with their PC. It consumes the controller's PCSrc decision as a redirect, flushing buffered and in-flight instructions.

## Interface
- XLEN, 32: address/data width.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DEPTH, 2: instruction buffer entries (power of two, ≥2).

- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- imem_req  out  1  request valid.
- imem_addr  out  XLEN  word address of the request; bits [1:0] always 0.
- imem_gnt  in  1  memory accepts the request this cycle (req & gnt = handshake).
- imem_rvalid  in  1  response data valid; at most one per granted request, in order, ≥1 cycle after grant.
- imem_rdata  in  XLEN  instruction word.
- instr_valid  out  1  buffer head valid.
- instr_ready  in  1  decode accepts head (valid & ready = pop).
- instr  out  XLEN  head instruction; op = instr[6:0], funct3 = instr[14:12], funct7b5 = instr[30].
- instr_pc  out  XLEN  PC of head instruction.
- instr_pcplus4  out  XLEN  instr_pc + 4, modulo 2^XLEN.
- redirect  in  1  PCSrc from controller (branch taken or jump).
- redirect_target  in  XLEN  new PC; bits [1:0] ignored (forced 0).

## Operation
- FSM states: IDLE, FETCH, WAIT.
- IDLE: entered on reset. Unconditionally moves to FETCH next cycle.
- FETCH:
  - imem_req = 1 iff FIFO count < DEPTH.
  - imem_addr = fetch_pc.
  - On req & gnt: latch req_pc = fetch_pc, fetch_pc += 4, go to WAIT.
- WAIT:
  - imem_req = 0; exactly one request is outstanding.
  - On imem_rvalid: if not stale, push {imem_rdata, req_pc}. Clear stale and go to FETCH.
- Space rule: a request is issued only if the FIFO has a free slot. A push therefore never meets a full FIFO.
- Redirect, any state:
  - fetch_pc ← {redirect_target[XLEN-1:2], 2'b00}.
  - FIFO flushed; instr_valid = 0 next cycle.
  - If in WAIT, or entering WAIT this cycle via req & gnt: stale ← 1, so the matching response is dropped.
- Simultaneous events:
  - redirect + rvalid: response dropped, go to FETCH.
  - redirect + pop: flush wins.
  - redirect + gnt: the granted request is stale, and fetch_pc takes the target (not +4).
  - push + pop in the same cycle: count unchanged.
- fetch_pc wraps modulo 2^XLEN.
- Reset mid-operation: all state is cleared asynchronously. An outstanding response arriving after reset is ignored, because the FSM is not in WAIT.

## Timing
- Reset values:
  - imem_req = 0, imem_addr = RESET_PC.
  - instr_valid = 0, instr = 0, instr_pc = 0, instr_pcplus4 = 4.
  - state = IDLE, count = 0, stale = 0.
- First imem_req = 1 in the 2nd rising edge after rst_n deasserts (IDLE→FETCH).
- imem_req/imem_addr are held stable until gnt, except on redirect.
- FIFO outputs come from registered storage. Latency is rvalid at cycle t → instr_valid at cycle t+1.
- Throughput: one request per two cycles minimum (grant cycle, then WAIT ≥1 cycle).
- Redirect takes effect at the next edge. The first post-redirect request appears the following cycle if no request is outstanding.

## Structure
- Shared package riscv_pkg:
  - XLEN, RESET_PC.
  - fetch_state_t enum {IDLE, FETCH, WAIT}.
  - Packed type fetch_entry_t {instr, pc}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH.
  - Ports: push, pop, flush, full, empty, count.
  - flush overrides push and pop.
- fetch_unit contains the FSM, fetch_pc, req_pc, and the stale flag.

## Test plan
- Reset/stream: rst_n low then high; memory grants immediately with 1-cycle response, decode always ready → requests at 0x0, 0x4, 0x8; instr_pc sequence 0x0, 0x4, 0x8 with the matching rdata; instr_pcplus4 = 0x4, 0x8, 0xC.
- Backpressure: instr_ready = 0 → after 2 pushes imem_req stays 0; raise ready → fetch resumes at 0x8, no loss or duplication.
- Redirect in WAIT: grant at 0x10, redirect to 0x103 before rvalid → response dropped; next request at 0x100; first instr_pc = 0x100.
- Redirect + gnt same cycle: grant at 0x20 with redirect to 0x40 → the 0x20 response is discarded; next request at 0x40, not 0x44.
- Wrap: RESET_PC = 0xFFFF_FFFC → requests at 0xFFFF_FFFC then 0x0000_0000; instr_pcplus4 of the first = 0x0.
- Async reset mid-WAIT: drop rst_n between grant and rvalid → outputs return to reset values immediately; the late rvalid is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-path types and constants for the RISC-V core
package riscv_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer of fetch entries; flush overrides push and pop
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is reset so the head reads as all-zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, imem request/grant/response sequencing and redirect flush
module fetch_unit #(
    parameter int                XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_PC = riscv_pkg::RESET_PC,
    parameter int                DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pcplus4,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target
);

    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            stale;
    logic            fire;
    logic            push;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    fetch_entry_t    wentry;
    fetch_entry_t    head;

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        push     = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = (count < CW'(DEPTH));
                if (imem_req && imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push    = !stale && !redirect && !full;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fire = imem_req && imem_gnt;

    // A redirect that lands while a request is (or is becoming) outstanding
    // marks that request stale so its response is dropped on arrival.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            stale    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                req_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= {redirect_target[XLEN-1:2], 2'b00};
            end else if (fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (redirect && ((state_q == WAIT && !imem_rvalid) || fire)) begin
                stale <= 1'b1;
            end else if (state_q == WAIT && imem_rvalid) begin
                stale <= 1'b0;
            end
        end
    end

    assign imem_addr    = fetch_pc;
    assign wentry.instr = imem_rdata;
    assign wentry.pc    = req_pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (instr_ready),
        .flush (redirect),
        .wdata (wentry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign instr_valid   = !empty;
    assign instr         = head.instr;
    assign instr_pc      = head.pc;
    assign instr_pcplus4 = head.pc + XLEN'(4);

endmodule
